fpu_issue_sched: RTL and testbench

Issue scheduler and float write-port arbiter for the multi-cycle FPU behind the decode stage. It holds one outstanding FPU operation, times its latency, and stalls decode on structural and float-register RAW/WAW hazards. When the operation completes, it shares the float register-file write port with pipeline float writebacks (loads, moves); the pipeline always has priority.

---
 rtl/fpu_issue_sched_if.sv | 33 +++
 rtl/fpu_issue_sched.sv | 106 ++++++++++
 tb/tb_fpu_issue_sched.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_sched_if.sv
// Decode-side, pipeline-writeback and FPU-control bundle of the FPU issue scheduler.
// The slave modport is the scheduler; the master modport is the decode/pipeline side.
`timescale 1ns/1ps
interface fpu_issue_sched_if;
  logic       issue_valid;
  logic [4:0] issue_op;
  logic [4:0] id_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_reads_f;
  logic       id_writes_f;
  logic       pipe_wef;
  logic [4:0] pipe_wa;
  logic       stall;
  logic       fpu_start;
  logic [4:0] fpu_op;
  logic       wb_en;
  logic       wb_sel;
  logic [4:0] wb_addr;
  logic       busy;

  modport slave (
    input  issue_valid, issue_op, id_rd, id_rs1, id_rs2, id_reads_f, id_writes_f,
    input  pipe_wef, pipe_wa,
    output stall, fpu_start, fpu_op, wb_en, wb_sel, wb_addr, busy
  );

  modport master (
    output issue_valid, issue_op, id_rd, id_rs1, id_rs2, id_reads_f, id_writes_f,
    output pipe_wef, pipe_wa,
    input  stall, fpu_start, fpu_op, wb_en, wb_sel, wb_addr, busy
  );
endinterface

// File: rtl/fpu_issue_sched.sv
// Single-outstanding FPU issue scheduler: times op latency, stalls decode on hazards,
// and arbitrates the float register-file write port with pipeline priority.
`timescale 1ns/1ps
module fpu_issue_sched #(
  parameter int LAT_ADD = 3,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fpu_issue_sched_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state, state_nxt;
  logic       pend_valid;
  logic [4:0] pend_rd;
  logic [7:0] cnt;
  logic       fpu_start;
  logic [4:0] fpu_op;
  logic       hazard;
  logic       stall;
  logic       accept;
  logic       wb_commit;
  logic       wb_en;
  logic       wb_sel;
  logic [4:0] wb_addr;

  function automatic logic [7:0] op_latency(input logic [4:0] op);
    case (op)
      5'd1, 5'd2: return 8'(LAT_ADD);
      5'd3:       return 8'(LAT_MUL);
      5'd4, 5'd5: return 8'(LAT_DIV);
      default:    return 8'd1;
    endcase
  endfunction

  always_comb begin
    hazard = pend_valid &&
             ((bus.id_reads_f && (bus.id_rs1 == pend_rd || bus.id_rs2 == pend_rd)) ||
              (bus.id_writes_f && bus.id_rd == pend_rd));
    stall  = hazard || (bus.issue_valid && bus.issue_op != 5'd0 && state != IDLE);
    accept = (state == IDLE) && bus.issue_valid && bus.issue_op != 5'd0 && !stall;
    // The FPU result only wins the port in a WB cycle the pipeline leaves free.
    wb_commit = (state == WB) && !bus.pipe_wef;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (cnt == 8'd1) state_nxt = WB;
      WB:      if (!bus.pipe_wef) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_en   = bus.pipe_wef;
    wb_sel  = 1'b0;
    wb_addr = bus.pipe_wa;
    if (state == WB) begin
      wb_en = 1'b1;
      if (!bus.pipe_wef) begin
        wb_sel  = 1'b1;
        wb_addr = pend_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      cnt        <= 8'd0;
      fpu_start  <= 1'b0;
      fpu_op     <= 5'd0;
    end else begin
      state     <= state_nxt;
      fpu_start <= accept;
      if (accept) begin
        fpu_op     <= bus.issue_op;
        pend_valid <= 1'b1;
        cnt        <= op_latency(bus.issue_op);
      end else begin
        if (state == EXEC) cnt <= cnt - 8'd1;
        if (wb_commit) pend_valid <= 1'b0;
      end
    end
  end

  // Destination tag is only meaningful while pend_valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) pend_rd <= bus.id_rd;
  end

  assign bus.stall     = stall;
  assign bus.fpu_start = fpu_start;
  assign bus.fpu_op    = fpu_op;
  assign bus.wb_en     = wb_en;
  assign bus.wb_sel    = wb_sel;
  assign bus.wb_addr   = wb_addr;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed bench for fpu_issue_sched: latency, hazards, structural stall, port arbitration, reset.
`timescale 1ns/1ps
module tb_fpu_issue_sched;
  logic clk;
  logic rst_n;
  fpu_issue_sched_if bus ();

  fpu_issue_sched #(.LAT_ADD(3), .LAT_MUL(4), .LAT_DIV(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_chk = 0;
  int         n_err = 0;
  int         fpu_wr_cnt = 0;
  logic [4:0] exp_pend_rd = 5'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    bus.issue_valid = 1'b0;
    bus.issue_op    = 5'd0;
    bus.id_rd       = 5'd0;
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_reads_f  = 1'b0;
    bus.id_writes_f = 1'b0;
    bus.pipe_wef    = 1'b0;
    bus.pipe_wa     = 5'd0;
  endtask

  task automatic present_op(input logic [4:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.id_rd       = rd;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_reads_f  = 1'b1;
    bus.id_writes_f = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (bus.busy && n < 40) begin
      tick();
      n++;
    end
    chk(tag, bus.busy, 1'b0);
  endtask

  // Port monitor: counts FPU writes, and flags any pipeline write to the pending destination.
  always @(negedge clk) begin
    if (rst_n && bus.wb_en && bus.wb_sel) fpu_wr_cnt++;
    if (rst_n && bus.busy && bus.wb_en && !bus.wb_sel)
      chk("waw_port", (bus.wb_addr == exp_pend_rd), 1'b0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int wr_before;
    rst_n = 1'b0;
    clr();
    bus.pipe_wef = 1'b1;
    bus.pipe_wa  = 5'd12;
    #3;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_start", bus.fpu_start, 1'b0);
    chk("rst_fpu_op", bus.fpu_op, 5'd0);
    chk("rst_wb_en", bus.wb_en, 1'b1);
    chk("rst_wb_sel", bus.wb_sel, 1'b0);
    chk("rst_wb_addr", bus.wb_addr, 5'd12);
    tick();
    tick();
    clr();
    rst_n = 1'b1;
    tick();

    // op code 0 is not an FPU op
    present_op(5'd0, 5'd3, 5'd1, 5'd2);
    settle();
    chk("op0_stall", bus.stall, 1'b0);
    tick();
    clr();
    settle();
    chk("op0_busy", bus.busy, 1'b0);
    chk("op0_start", bus.fpu_start, 1'b0);
    tick();

    // single add rd=5
    present_op(5'd1, 5'd5, 5'd1, 5'd2);
    exp_pend_rd = 5'd5;
    settle();
    chk("add_stall", bus.stall, 1'b0);
    tick();
    clr();
    settle();
    chk("add_start", bus.fpu_start, 1'b1);
    chk("add_busy", bus.busy, 1'b1);
    chk("add_fpu_op", bus.fpu_op, 5'd1);
    chk("add_wb_en_t1", bus.wb_en, 1'b0);
    tick();
    chk("add_start_t2", bus.fpu_start, 1'b0);
    tick();
    chk("add_wb_en_t3", bus.wb_en, 1'b0);
    tick();
    chk("add_wb_en_t4", bus.wb_en, 1'b1);
    chk("add_wb_sel_t4", bus.wb_sel, 1'b1);
    chk("add_wb_addr_t4", bus.wb_addr, 5'd5);
    tick();
    chk("add_busy_t5", bus.busy, 1'b0);
    chk("add_wb_en_t5", bus.wb_en, 1'b0);

    // RAW: mul rd=7, reader of rs1=7 stalls through T+5
    present_op(5'd3, 5'd7, 5'd1, 5'd2);
    exp_pend_rd = 5'd7;
    tick();
    clr();
    bus.id_reads_f = 1'b1;
    bus.id_rs1     = 5'd7;
    for (int i = 1; i <= 5; i++) begin
      settle();
      chk("raw_stall", bus.stall, 1'b1);
      chk("raw_wb_sel", bus.wb_sel, (i == 5));
      tick();
    end
    chk("raw_stall_t6", bus.stall, 1'b0);
    chk("raw_busy_t6", bus.busy, 1'b0);
    clr();
    tick();

    // Structural: div rd=10, then independent add rd=11
    present_op(5'd4, 5'd10, 5'd1, 5'd2);
    exp_pend_rd = 5'd10;
    settle();
    chk("div_stall", bus.stall, 1'b0);
    tick();
    present_op(5'd1, 5'd11, 5'd3, 5'd4);
    n = 0;
    settle();
    while (bus.stall && n < 30) begin
      n++;
      tick();
    end
    chk("struct_stall_cycles", n, 17);
    chk("struct_idle", bus.busy, 1'b0);
    exp_pend_rd = 5'd11;
    tick();
    clr();
    settle();
    chk("struct_start", bus.fpu_start, 1'b1);
    chk("struct_fpu_op", bus.fpu_op, 5'd1);
    chk("struct_busy", bus.busy, 1'b1);
    drain("struct_drain");
    tick();

    // Write-port conflict: sub rd=9, pipeline writes 3 for two WB cycles
    present_op(5'd2, 5'd9, 5'd1, 5'd2);
    exp_pend_rd = 5'd9;
    tick();
    clr();
    tick();
    tick();
    tick();
    bus.pipe_wef = 1'b1;
    bus.pipe_wa  = 5'd3;
    settle();
    chk("conf_en_0", bus.wb_en, 1'b1);
    chk("conf_sel_0", bus.wb_sel, 1'b0);
    chk("conf_addr_0", bus.wb_addr, 5'd3);
    chk("conf_busy_0", bus.busy, 1'b1);
    tick();
    chk("conf_sel_1", bus.wb_sel, 1'b0);
    chk("conf_addr_1", bus.wb_addr, 5'd3);
    tick();
    bus.pipe_wef = 1'b0;
    settle();
    chk("conf_en_2", bus.wb_en, 1'b1);
    chk("conf_sel_2", bus.wb_sel, 1'b1);
    chk("conf_addr_2", bus.wb_addr, 5'd9);
    tick();
    chk("conf_busy_3", bus.busy, 1'b0);
    clr();
    tick();

    // WAW: mul rd=9, load writing rd=9 stalls until the FPU write commits
    present_op(5'd3, 5'd9, 5'd1, 5'd2);
    exp_pend_rd = 5'd9;
    tick();
    clr();
    bus.id_writes_f = 1'b1;
    bus.id_rd       = 5'd9;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("waw_stall", bus.stall, 1'b1);
      tick();
    end
    bus.pipe_wef = 1'b1;
    bus.pipe_wa  = 5'd4;
    settle();
    chk("waw_stall_wb0", bus.stall, 1'b1);
    chk("waw_sel_wb0", bus.wb_sel, 1'b0);
    chk("waw_addr_wb0", bus.wb_addr, 5'd4);
    tick();
    bus.pipe_wef = 1'b0;
    settle();
    chk("waw_stall_wb1", bus.stall, 1'b1);
    chk("waw_sel_wb1", bus.wb_sel, 1'b1);
    chk("waw_addr_wb1", bus.wb_addr, 5'd9);
    tick();
    chk("waw_stall_free", bus.stall, 1'b0);
    chk("waw_busy_free", bus.busy, 1'b0);
    tick();
    clr();
    bus.pipe_wef = 1'b1;
    bus.pipe_wa  = 5'd9;
    settle();
    chk("waw_load_en", bus.wb_en, 1'b1);
    chk("waw_load_addr", bus.wb_addr, 5'd9);
    chk("waw_load_sel", bus.wb_sel, 1'b0);
    tick();
    clr();

    // Latency-1 op (code 7) rd=6
    present_op(5'd7, 5'd6, 5'd1, 5'd2);
    exp_pend_rd = 5'd6;
    tick();
    clr();
    settle();
    chk("l1_start", bus.fpu_start, 1'b1);
    chk("l1_wb_en_t1", bus.wb_en, 1'b0);
    tick();
    chk("l1_wb_sel_t2", bus.wb_sel, 1'b1);
    chk("l1_wb_addr_t2", bus.wb_addr, 5'd6);
    tick();
    chk("l1_busy_t3", bus.busy, 1'b0);

    // Reset mid-EXEC of a div rd=10
    present_op(5'd4, 5'd10, 5'd1, 5'd2);
    exp_pend_rd = 5'd10;
    tick();
    clr();
    tick();
    tick();
    tick();
    tick();
    chk("mid_busy", bus.busy, 1'b1);
    wr_before = fpu_wr_cnt;
    present_op(5'd1, 5'd12, 5'd10, 5'd2);
    rst_n = 1'b0;
    settle();
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_stall", bus.stall, 1'b0);
    chk("mid_rst_start", bus.fpu_start, 1'b0);
    chk("mid_rst_fpu_op", bus.fpu_op, 5'd0);
    tick();
    clr();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_rst_no_write", fpu_wr_cnt, wr_before);
    chk("mid_rst_idle", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
